// File: rtl/adder_logic_pkg.sv
`default_nettype none
// ============================================================================
// adder_logic_pkg : shared constants for the adder_logic slice
// Revision 1.0 : initial release
// ============================================================================
package adder_logic_pkg;

   localparam int c_default_width = 3;

endpackage : adder_logic_pkg
`default_nettype wire

// File: rtl/adder_logic_full_adder.sv
`default_nettype none
// ============================================================================
// full_adder : one-bit full adder cell used by the adder_logic ripple chain
// Revision 1.0 : initial release
// ============================================================================
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic w_prop;

   assign w_prop = a ^ b;
   assign s      = w_prop ^ cin;
   assign cout   = (a & b) | (cin & w_prop);

endmodule : full_adder
`default_nettype wire

// File: rtl/adder_logic.sv
`default_nettype none
// ============================================================================
// adder_logic : ripple-carry adder with a registered copy and valid flag
// Revision 1.0 : initial release
// ============================================================================
module adder_logic
   import adder_logic_pkg::*;
#(
   parameter int WIDTH = c_default_width
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   sum,
   output logic [WIDTH:0]   sum_q,
   output logic             sum_valid
);

   logic [WIDTH:0] w_carry;
   logic [WIDTH:0] r_sum_q;
   logic           r_sum_valid;

   assign w_carry[0] = 1'b0;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_carry[i]),
            .s    (sum[i]),
            .cout (w_carry[i+1])
         );
      end
   endgenerate

   // The final carry-out becomes the extra sum bit, so the result never wraps.
   assign sum[WIDTH] = w_carry[WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sum_q     <= '0;
         r_sum_valid <= 1'b0;
      end else begin
         r_sum_q     <= sum;
         r_sum_valid <= 1'b1;
      end
   end

   assign sum_q     = r_sum_q;
   assign sum_valid = r_sum_valid;

endmodule : adder_logic
`default_nettype wire

// File: tb/tb_adder_logic.sv
`default_nettype none
// ============================================================================
// tb_adder_logic : table-driven, scoreboarded check of adder_logic (WIDTH=3)
// Revision 1.0 : initial release
// ============================================================================
module tb_adder_logic;

   localparam int W = 3;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   exp_sum;
   } vec_t;

   logic         clk;
   logic         reset;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W:0]   sum;
   logic [W:0]   sum_q;
   logic         sum_valid;

   int           checks;
   int           failures;
   logic [W:0]   sb_q[$];
   vec_t         vecs[67];

   adder_logic #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .sum       (sum),
      .sum_q     (sum_q),
      .sum_valid (sum_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 10)
            $display("FAIL %s a=%0d(%b) b=%0d(%b) actual=%0d(%b) expected=%0d(%b)",
                     name, a, a, b, b, act, act, exp, exp);
         else
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Drive one operand pair just after a falling edge, then after a 10-unit
   // settle (one rising edge later) check the sum and the scoreboarded sum_q.
   task automatic step(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W:0] exp, input string name);
      logic [W:0] e;
      a = va;
      b = vb;
      sb_q.push_back(exp);
      @(negedge clk);
      check({name, "_sum"}, sum, exp);
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_scoreboard_empty actual=0 expected=1", name);
      end else begin
         e = sb_q.pop_front();
         check({name, "_sum_q"}, sum_q, e);
      end
      check({name, "_valid"}, {3'b000, sum_valid}, 4'd1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      for (int i = 0; i < 64; i++) begin
         vecs[i].a       = i[5:3];
         vecs[i].b       = i[2:0];
         vecs[i].exp_sum = {1'b0, i[5:3]} + {1'b0, i[2:0]};
      end
      vecs[64] = '{a: 3'd7, b: 3'd7, exp_sum: 4'd14};
      vecs[65] = '{a: 3'd5, b: 3'd3, exp_sum: 4'd8};
      vecs[66] = '{a: 3'd7, b: 3'd1, exp_sum: 4'd8};

      // Reset held for two edges; sum stays combinational throughout.
      reset = 1'b1;
      a     = 3'd6;
      b     = 3'd5;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_sum", sum, 4'd11);
      check("reset_sum_q", sum_q, 4'd0);
      check("reset_valid", {3'b000, sum_valid}, 4'd0);

      // First capture after deassertion, then an input change between edges.
      reset = 1'b0;
      step(3'd2, 3'd3, 4'd5, "latency");
      a = 3'd1;
      b = 3'd1;
      #1;
      check("latency_comb_sum", sum, 4'd2);
      check("latency_hold_sum_q", sum_q, 4'd5);
      @(negedge clk);
      check("latency_next_sum_q", sum_q, 4'd2);

      for (int i = 0; i < 67; i++)
         step(vecs[i].a, vecs[i].b, vecs[i].exp_sum, $sformatf("vec%0d", i));

      // Mid-operation reset with sum_q holding 14.
      step(3'd7, 3'd7, 4'd14, "pre_midreset");
      reset = 1'b1;
      @(negedge clk);
      check("midreset_sum", sum, 4'd14);
      check("midreset_sum_q", sum_q, 4'd0);
      check("midreset_valid", {3'b000, sum_valid}, 4'd0);
      reset = 1'b0;
      sb_q.delete();
      step(3'd4, 3'd2, 4'd6, "post_midreset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_adder_logic
`default_nettype wire

// File: doc/adder_logic.md
ADDER_LOGIC -- requirements
Module: adder_logic

Interface
REQ-001 Parameter: WIDTH, default 3, operand width in bits; sum width is WIDTH+1.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset; synchronous and active-high.
REQ-004 Port: a  input  WIDTH  unsigned operand A.
REQ-005 Port: b  input  WIDTH  unsigned operand B.
REQ-006 Port: sum  output  WIDTH+1  combinational unsigned sum of a and b; MSB is the carry-out.
REQ-007 Port: sum_q  output  WIDTH+1  registered copy of sum.
REQ-008 Port: sum_valid  output  1  high when sum_q holds a sum captured since the last reset.

Function
REQ-009 sum SHALL equal a + b, zero-extended to WIDTH+1 bits, for all 2^(2*WIDTH) operand pairs; no truncation and no wrap.
REQ-010 sum SHALL be purely combinational from a and b, with no dependence on clk or reset, and settle within the same evaluation as an input change.
REQ-011 The adder SHALL be built as a ripple-carry chain of explicit full-adder logic: per bit s = a XOR b XOR cin and cout = (a AND b) OR (cin AND (a XOR b)); the language '+' operator SHALL NOT be used for the datapath.
REQ-012 The carry-in of bit 0 SHALL be constant 0.
REQ-013 The carry-out of bit WIDTH-1 SHALL drive sum[WIDTH].
REQ-014 On every rising clk edge with reset low, sum_q SHALL load the current sum, giving 1-cycle latency.
REQ-015 On every rising clk edge with reset low, sum_valid SHALL be set to 1.
REQ-016 X/Z on any operand bit MAY propagate to sum; a known operand SHALL always yield a known sum.

Reset
REQ-017 When reset is high at a rising clk edge, sum_q SHALL become 0.
REQ-018 When reset is high at a rising clk edge, sum_valid SHALL become 0.
REQ-019 Reset SHALL NOT affect the combinational output sum.
REQ-020 If reset is asserted mid-operation, the registered outputs SHALL clear on that edge, and the first edge after deassertion SHALL capture the sum current at that edge.

Structure
REQ-021 A shared package adder_logic_pkg SHALL hold the default WIDTH constant.
REQ-022 One sub-module, full_adder (ports a, b, cin, s, cout), SHALL be instantiated WIDTH times via a generate loop.
REQ-023 The top level SHALL contain only the carry chain wiring, the output register, and the valid flag.

Verification
REQ-024 Exhaustive test: all 64 (a,b) pairs with WIDTH=3, checking sum after a 10-time-unit settle; sum SHALL equal the 4-bit a+b for every pair (e.g. 0+0 -> 0000, 3+4 -> 0111).
REQ-025 Carry boundary: a=7, b=7 -> sum=14 (1110); a=5, b=3 -> sum=8 (1000); a=7, b=1 -> sum=8 (1000).
REQ-026 Reset: assert reset for 2 edges with a=6, b=5 -> sum=11 combinationally, while sum_q=0 and sum_valid=0.
REQ-027 Latency: deassert reset, apply a=2, b=3 -> after 1 edge sum_q=5 and sum_valid=1; change to a=1, b=1 -> sum=2 immediately, while sum_q remains 5 until the next edge.
REQ-028 Mid-operation reset: with sum_q=14, assert reset for 1 edge -> sum_q=0 and sum_valid=0; the next edge with reset low reloads the current sum.
REQ-029 The bench SHALL report at most 10 mismatches with operands, expected and actual values in decimal and binary, then print a pass/fail summary.
